// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider scheduler and its iteration core.
package div_sched_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  localparam int DEF_WIDTH = 8;
  localparam int NUM_PORTS = 2;
endpackage

// File: rtl/div_iter_core.sv
// Restoring divider datapath: one quotient bit per step, WIDTH steps per division.
module div_iter_core
  import div_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             last_o,
  output logic [WIDTH-1:0] quo_next_o,
  output logic [WIDTH-1:0] rem_next_o
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] quo_q, rem_q, dvr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  // The shifted remainder needs one extra bit; the difference always fits WIDTH bits.
  always_comb begin
    rem_sh     = {rem_q, quo_q[WIDTH-1]};
    diff       = rem_sh[WIDTH-1:0] - dvr_q;
    rem_next_o = rem_sh[WIDTH-1:0];
    quo_next_o = {quo_q[WIDTH-2:0], 1'b0};
    if (rem_sh >= {1'b0, dvr_q}) begin
      rem_next_o = diff;
      quo_next_o = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (load_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dvr_q <= divisor_i;
      cnt_q <= '0;
    end else if (step_i) begin
      quo_q <= quo_next_o;
      rem_q <= rem_next_o;
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/div_sched.sv
// Two-port round-robin scheduler for one shared iterative divider.
// Optional DIV_SCHED_DBZ_FAST_EN: zero divisor skips CALC and responds in cycle 1.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_valid,
  output logic [NUM_PORTS-1:0] req_ready,
  input  logic [WIDTH-1:0]     req_div0,
  input  logic [WIDTH-1:0]     req_dvr0,
  input  logic [WIDTH-1:0]     req_div1,
  input  logic [WIDTH-1:0]     req_dvr1,
  output logic [NUM_PORTS-1:0] rsp_valid,
  output logic [WIDTH-1:0]     rsp_quotient,
  output logic [WIDTH-1:0]     rsp_remainder,
  output logic                 rsp_dbz,
  output logic                 busy
);
  state_e                 state_q;
  logic                   last_q;
  logic                   owner_q;
  logic                   dbz_q;
  logic [NUM_PORTS-1:0]   rsp_valid_q;
  logic [WIDTH-1:0]       rsp_quo_q, rsp_rem_q;
  logic                   rsp_dbz_q;

  logic [NUM_PORTS-1:0]   grant;
  logic                   xfer, sel;
  logic [WIDTH-1:0]       sel_div, sel_dvr;
  logic                   core_last;
  logic [WIDTH-1:0]       core_quo, core_rem;

  // Arbiter: on contention the port not served most recently wins.
  always_comb begin
    grant = '0;
    if (!rst && state_q == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

  assign req_ready = grant;
  assign xfer      = |(req_valid & grant);
  assign sel       = grant[1];
  assign sel_div   = sel ? req_div1 : req_div0;
  assign sel_dvr   = sel ? req_dvr1 : req_dvr0;

  div_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .load_i     (xfer),
    .step_i     (state_q == CALC),
    .dividend_i (sel_div),
    .divisor_i  (sel_dvr),
    .last_o     (core_last),
    .quo_next_o (core_quo),
    .rem_next_o (core_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      dbz_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_quo_q   <= '0;
      rsp_rem_q   <= '0;
      rsp_dbz_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            owner_q <= sel;
            last_q  <= sel;
            dbz_q   <= (sel_dvr == '0);
`ifdef DIV_SCHED_DBZ_FAST_EN
            if (sel_dvr == '0) begin
              state_q     <= DONE;
              rsp_valid_q <= NUM_PORTS'(1) << sel;
              rsp_quo_q   <= '1;
              rsp_rem_q   <= sel_div;
              rsp_dbz_q   <= 1'b1;
            end else begin
              state_q <= CALC;
            end
`else
            state_q <= CALC;
`endif
          end
        end
        CALC: begin
          // Final iteration result goes straight into the output registers.
          if (core_last) begin
            state_q     <= DONE;
            rsp_valid_q <= NUM_PORTS'(1) << owner_q;
            rsp_quo_q   <= core_quo;
            rsp_rem_q   <= core_rem;
            rsp_dbz_q   <= dbz_q;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_quotient  = rsp_quo_q;
  assign rsp_remainder = rsp_rem_q;
  assign rsp_dbz       = rsp_dbz_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched: table-driven divisions plus arbitration and reset sequences.
module tb_div_sched;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [1:0]   req_valid, req_ready, rsp_valid;
  logic [W-1:0] req_div0, req_dvr0, req_div1, req_dvr1;
  logic [W-1:0] rsp_quotient, rsp_remainder;
  logic         rsp_dbz, busy;

  int n_chk  = 0;
  int n_pass = 0;

  div_sched #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_div0      (req_div0),
    .req_dvr0      (req_dvr0),
    .req_div1      (req_div1),
    .req_dvr1      (req_dvr1),
    .rsp_valid     (rsp_valid),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_dbz       (rsp_dbz),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         p;
    logic [W-1:0] a, b, q, r;
    logic         dbz;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 1 after a transfer; returns the cycle in which rsp_valid rose.
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 1; i <= 2 * W + 4; i++) begin
      if (rsp_valid != 2'b00) begin
        lat = i;
        break;
      end
      tick();
    end
    if (lat < 0) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input vec_t v, input string tag);
    logic [1:0] oh;
    int         lat, exp_lat;
    oh      = v.p ? 2'b10 : 2'b01;
    exp_lat = W + 1;
`ifdef DIV_SCHED_DBZ_FAST_EN
    if (v.dbz) exp_lat = 1;
`endif
    req_valid = oh;
    req_div0  = v.p ? 8'hA5 : v.a;
    req_dvr0  = v.p ? 8'h03 : v.b;
    req_div1  = v.p ? v.a : 8'hA5;
    req_dvr1  = v.p ? v.b : 8'h03;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(oh));
    tick();
    req_valid = 2'b00;
    req_div0  = 8'h5A; req_dvr0 = 8'h00;
    req_div1  = 8'h5A; req_dvr1 = 8'h00;
    #1;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_rsp(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_owner"}, 32'(rsp_valid), 32'(oh));
    chk({tag, "_q"}, 32'(rsp_quotient), 32'(v.q));
    chk({tag, "_r"}, 32'(rsp_remainder), 32'(v.r));
    chk({tag, "_dbz"}, 32'(rsp_dbz), 32'(v.dbz));
    tick();
    chk({tag, "_strobe"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, 32'(rsp_quotient), 32'(v.q));
  endtask

  initial begin
    int lat;
    int seen;
    logic [1:0] oh;

    vecs[0] = '{1'b0, 8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
    vecs[1] = '{1'b1, 8'd173, 8'd0,   8'd255, 8'd173, 1'b1};
    vecs[2] = '{1'b0, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[3] = '{1'b1, 8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
    vecs[4] = '{1'b0, 8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vecs[5] = '{1'b1, 8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    vecs[6] = '{1'b0, 8'd0,   8'd0,   8'd255, 8'd0,   1'b1};
    vecs[7] = '{1'b1, 8'd201, 8'd16,  8'd12,  8'd9,   1'b0};

    rst = 1'b1;
    req_valid = 2'b00;
    req_div0 = '0; req_dvr0 = '0; req_div1 = '0; req_dvr1 = '0;
    tick();
    tick();

    // Reset state, with both ports already requesting.
    req_valid = 2'b11;
    req_div0 = 8'd100; req_dvr0 = 8'd10;
    req_div1 = 8'd9;   req_dvr1 = 8'd4;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_q", 32'(rsp_quotient), 32'd0);
    chk("rst_r", 32'(rsp_remainder), 32'd0);
    chk("rst_dbz", 32'(rsp_dbz), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Contention straight after reset: port 0 first, port 1 in cycle 10.
    rst = 1'b0;
    #1;
    chk("arb_first", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b10;
    #1;
    chk("arb_no_ready_busy", 32'(req_ready), 32'd0);
    wait_rsp(lat);
    chk("arb_p0_lat", 32'(lat), 32'(W + 1));
    chk("arb_p0_owner", 32'(rsp_valid), 32'd1);
    chk("arb_p0_q", 32'(rsp_quotient), 32'd10);
    chk("arb_p0_r", 32'(rsp_remainder), 32'd0);
    tick();
    chk("arb_second", 32'(req_ready), 32'd2);
    tick();
    req_valid = 2'b00;
    wait_rsp(lat);
    chk("arb_p1_lat", 32'(lat), 32'(W + 1));
    chk("arb_p1_owner", 32'(rsp_valid), 32'd2);
    chk("arb_p1_q", 32'(rsp_quotient), 32'd2);
    chk("arb_p1_r", 32'(rsp_remainder), 32'd1);
    tick();

    // Both ports held valid: grants alternate starting with port 0.
    req_valid = 2'b11;
    req_div0 = 8'd50; req_dvr0 = 8'd3;
    req_div1 = 8'd77; req_dvr1 = 8'd8;
    for (int k = 0; k < 4; k++) begin
      oh = (k % 2 == 1) ? 2'b10 : 2'b01;
      #1;
      chk("alt_ready", 32'(req_ready), 32'(oh));
      tick();
      wait_rsp(lat);
      chk("alt_owner", 32'(rsp_valid), 32'(oh));
      chk("alt_q", 32'(rsp_quotient), (k % 2 == 1) ? 32'd9 : 32'd16);
      chk("alt_r", 32'(rsp_remainder), (k % 2 == 1) ? 32'd5 : 32'd2);
      tick();
    end
    req_valid = 2'b00;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the 4th CALC cycle of a port 0 operation.
    req_valid = 2'b01;
    req_div0 = 8'd200; req_dvr0 = 8'd7;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_q", 32'(rsp_quotient), 32'd0);
    chk("mid_rst_r", 32'(rsp_remainder), 32'd0);
    chk("mid_rst_dbz", 32'(rsp_dbz), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (rsp_valid != 2'b00) seen++;
      tick();
    end
    chk("mid_rst_no_rsp", 32'(seen), 32'd0);
    req_valid = 2'b11;
    req_div1 = 8'd9; req_dvr1 = 8'd4;
    #1;
    chk("mid_rst_grant_p0", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    wait_rsp(lat);
    chk("mid_rst_redo_owner", 32'(rsp_valid), 32'd1);
    chk("mid_rst_redo_q", 32'(rsp_quotient), 32'd28);
    chk("mid_rst_redo_r", 32'(rsp_remainder), 32'd4);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/div_sched.md
# div_sched

Sequencing controller and two-port arbiter for one shared iterative restoring divider on the Basys3 Abacus. It accepts divide requests from two requesters (e.g. switch front-end and display/BCD path) and grants them round-robin. It runs one quotient bit per clock and returns quotient, remainder and a divide-by-zero flag to the owning requester. It sits between the operand sources and the seven-segment formatting logic.

## Interface
- `WIDTH`, default 8: operand/result width; iteration count equals `WIDTH`.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 2: per-port request valid; bit i = port i.
- `req_ready` out 2: per-port grant/accept; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `req_div0` in WIDTH: port 0 dividend.
- `req_dvr0` in WIDTH: port 0 divisor.
- `req_div1` in WIDTH: port 1 dividend.
- `req_dvr1` in WIDTH: port 1 divisor.
- `rsp_valid` out 2: one-cycle result strobe to the owning port.
- `rsp_quotient` out WIDTH: quotient; held until the next result.
- `rsp_remainder` out WIDTH: remainder; held until the next result.
- `rsp_dbz` out 1: divisor was zero; held with the result.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE**
  - `req_ready` is one-hot toward the winning valid port, or zero if no port is valid.
  - Winner: the port not served most recently. If only one port is valid, that port wins.
  - On a transfer: latch dividend, divisor and owner id; set quotient reg = dividend, remainder reg = 0, count = 0; update the round-robin pointer to the owner; go to CALC.
- **CALC**, once per cycle:
  - {rem, quo} shifts left by 1.
  - If rem ≥ divisor: rem −= divisor and quo[0] = 1.
  - count increments. After iteration `WIDTH` completes, go to DONE.
- **DONE**
  - Drive `rsp_valid[owner]` = 1 for exactly one cycle.
  - Update the result outputs in this same cycle.
  - Return to IDLE.
- Divide by zero runs the same iterations and naturally yields quotient = all ones and remainder = dividend. `rsp_dbz` = 1.
- Requesters hold `req_valid` and their operands stable until they receive `req_ready`. The operand inputs are sampled only on the transfer cycle.
- The response path has no backpressure.
- Reset values: `req_ready` = 0 during reset, `rsp_valid` = 0, `rsp_quotient` = 0, `rsp_remainder` = 0, `rsp_dbz` = 0, `busy` = 0. State = IDLE; the round-robin pointer favours port 0.
- Reset mid-operation: the in-flight request is discarded and no `rsp_valid` is issued. That requester must re-request.

## Timing
- Transfer in cycle 0. CALC in cycles 1..WIDTH. DONE (`rsp_valid`) in cycle WIDTH+1. IDLE (`req_ready` possible) in cycle WIDTH+2.
- Throughput: one division every WIDTH+2 cycles (10 for WIDTH=8).
- `req_ready` is combinational from `req_valid` and state. It is never asserted outside IDLE.
- If both ports are valid in the same IDLE cycle, only one is granted. The other waits at most one operation.

## Configuration
- `DIV_SCHED_DBZ_FAST_EN`
  - Defined: a zero divisor is detected on the transfer cycle. CALC is skipped and DONE occurs in cycle 1. Results are still quotient = all ones, remainder = dividend, `rsp_dbz` = 1.
  - Undefined: a zero divisor takes the full WIDTH+1 latency.

## Structure
- Package `div_sched_pkg`: state enum (IDLE/CALC/DONE), default width constant, port-count constant (2).
- Sub-module `div_iter_core`: holds rem/quo/divisor registers and the iteration counter. Interface is load/step/last. `div_sched` keeps the arbiter, the FSM and the output registers.

## Test plan
- Port 0 sends 200/7 → `req_ready[0]` in cycle 0; `rsp_valid[0]` in cycle 9 with q=28, r=4, dbz=0; `busy` high in cycles 1–9.
- Both ports valid after reset, port 0 = 100/10 and port 1 = 9/4 → port 0 is served first (q=10, r=0) and port 1 is granted in cycle 10 (q=2, r=1 in cycle 19).
- Both ports held continuously valid for 4 operations → grants alternate 0,1,0,1, and each `rsp_valid` goes only to its owner.
- Port 1 sends 173/0 → q=255, r=173, dbz=1 in cycle 9; with `DIV_SCHED_DBZ_FAST_EN` the same result arrives in cycle 1.
- Boundaries: 255/1 → q=255, r=0; 5/9 → q=0, r=5; 255/255 → q=1, r=0.
- Assert `rst` in cycle 4 of CALC → no `rsp_valid`, all outputs 0. The first IDLE cycle after reset grants port 0.
